// File: rtl/psw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psw_pkg
// Description : Shared constants for the processor status word: flag bit
//               positions, ALU operation codes and the condition-code
//               qualification helper.
// Revision    : 1.0 - initial release
// ============================================================================
package psw_pkg;

    // Flag bit positions inside the PSW
    localparam int PSW_Z  = 0;
    localparam int PSW_N  = 1;
    localparam int PSW_C  = 2;
    localparam int PSW_V  = 3;
    localparam int PSW_IE = 4;

    // ALU operation codes that matter to the flag logic
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_NOCC0 = 3'b010;
    localparam logic [2:0] ALU_NOCC1 = 3'b111;

    // Highest IR opcode that is allowed to touch the condition codes
    localparam logic [3:0] CC_OPCODE_MAX = 4'd5;

    // True when the current instruction is allowed to write Z/N (and maybe C/V)
    function automatic logic cc_qualified(input logic [3:0] opcode,
                                          input logic       set_cc,
                                          input logic       result_valid,
                                          input logic [2:0] alu_op);
        return (opcode <= CC_OPCODE_MAX) && set_cc && result_valid &&
               (alu_op != ALU_NOCC0) && (alu_op != ALU_NOCC1);
    endfunction

    // Only arithmetic operations produce meaningful carry and overflow
    function automatic logic cc_arith(input logic [2:0] alu_op);
        return (alu_op == ALU_ADD) || (alu_op == ALU_SUB);
    endfunction

endpackage : psw_pkg
`default_nettype wire

// File: rtl/psw_lifo.sv
`default_nettype none
// ============================================================================
// Module      : psw_lifo
// Description : LIFO storage for saved PSW values. Entry cnt-1 is the top.
//               Push when full and pop when empty are ignored; the caller
//               is responsible for flagging those as errors.
// Revision    : 1.0 - initial release
// ============================================================================
module psw_lifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] top_out,
    output logic [CNT_W-1:0]  cnt,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];

    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // Write the slot just above the current top on an accepted push
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem[i] <= '0;
            end else if (push && !pop && !full && (cnt == CNT_W'(i))) begin
                mem[i] <= data_in;
            end
        end
    end

    // Occupancy counter: one step per accepted push or pop
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (push && !pop && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (pop && !push && !empty) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Present the current top entry (zero when the stack is empty)
    always_comb begin
        top_out = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (cnt == CNT_W'(i + 1)) begin
                top_out = mem[i];
            end
        end
    end

endmodule : psw_lifo
`default_nettype wire

// File: rtl/psw_stack.sv
`default_nettype none
// ============================================================================
// Module      : psw_stack
// Description : Processor status word with interrupt save/restore stack,
//               bus load/drive, ALU condition-code update and sticky
//               overflow/underflow error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module psw_stack
    import psw_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    inout  wire  [DATA_W-1:0] data,
    input  logic              latch,
    input  logic              enable,
    input  logic              z_in,
    input  logic [3:0]        ir_opcode,
    input  logic              ir_s,
    input  logic [2:0]        alu_control,
    input  logic              cc_z_in,
    input  logic              cc_n_in,
    input  logic              cc_c_in,
    input  logic              cc_v_in,
    input  logic              irq_push,
    input  logic              rti_pop,
    input  logic              err_clr,
    output logic [DATA_W-1:0] psw_out,
    output logic [4:0]        flags_out,
    output logic [CNT_W-1:0]  stack_cnt,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              ovf_err,
    output logic              unf_err
);

    logic [DATA_W-1:0] psw;
    logic [DATA_W-1:0] psw_next;
    logic [DATA_W-1:0] top_entry;
    logic              push_do;
    logic              pop_do;
    logic              ovf_set;
    logic              unf_set;

    psw_lifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_lifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push_do),
        .pop     (pop_do),
        .data_in (psw),
        .top_out (top_entry),
        .cnt     (stack_cnt),
        .full    (stack_full),
        .empty   (stack_empty)
    );

    // Priority resolution: one action per cycle, lower ones are dropped
    always_comb begin
        psw_next = psw;
        push_do  = 1'b0;
        pop_do   = 1'b0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (irq_push && rti_pop) begin
            // Tail-chained interrupt: stay in handler context, masked
            psw_next[PSW_IE] = 1'b0;
        end else if (rti_pop) begin
            if (stack_empty) begin
                unf_set = 1'b1;
            end else begin
                pop_do   = 1'b1;
                psw_next = top_entry;
            end
        end else if (irq_push) begin
            if (stack_full) begin
                ovf_set = 1'b1;
            end else begin
                push_do = 1'b1;
            end
            // Interrupts are masked on entry even if the save was lost
            psw_next[PSW_IE] = 1'b0;
        end else if (latch) begin
            psw_next = data;
        end else if (cc_qualified(ir_opcode, ir_s, z_in, alu_control)) begin
            psw_next[PSW_Z] = cc_z_in;
            psw_next[PSW_N] = cc_n_in;
            if (cc_arith(alu_control)) begin
                psw_next[PSW_C] = cc_c_in;
                psw_next[PSW_V] = cc_v_in;
            end
        end
    end

    // PSW register
    always_ff @(posedge clk) begin
        if (reset) begin
            psw <= '0;
        end else begin
            psw <= psw_next;
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (unf_set) begin
                unf_err <= 1'b1;
            end else if (err_clr) begin
                unf_err <= 1'b0;
            end
        end
    end

    assign psw_out   = psw;
    assign flags_out = psw[4:0];
    assign data      = enable ? psw : {DATA_W{1'bz}};

endmodule : psw_stack
`default_nettype wire

// File: tb/tb_psw_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_psw_stack
// Description : Directed scoreboard bench for psw_stack. A 16-bit/depth-4
//               instance and an 8-bit/depth-1 instance share the control
//               inputs; expected states are queued by the stimulus and
//               compared by a monitor on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psw_stack;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, latch, enable, z_in, ir_s, irq_push, rti_pop, err_clr;
    logic        cc_z, cc_n, cc_c, cc_v;
    logic [3:0]  ir_opcode;
    logic [2:0]  alu_control;
    logic        drv_en;
    logic [15:0] drv_val;

    wire  [15:0] data_a;
    wire  [7:0]  data_b;
    assign data_a = drv_en ? drv_val      : 16'hzzzz;
    assign data_b = drv_en ? drv_val[7:0] : 8'hzz;

    logic [15:0] psw_a;
    logic [4:0]  flags_a;
    logic [2:0]  cnt_a;
    logic        full_a, empty_a, ovf_a, unf_a;
    logic [7:0]  psw_b;
    logic [4:0]  flags_b;
    logic [0:0]  cnt_b;
    logic        full_b, empty_b, ovf_b, unf_b;

    psw_stack #(.DATA_W(16), .DEPTH(4)) u_dut_a (
        .clk(clk), .reset(reset), .data(data_a), .latch(latch), .enable(enable),
        .z_in(z_in), .ir_opcode(ir_opcode), .ir_s(ir_s), .alu_control(alu_control),
        .cc_z_in(cc_z), .cc_n_in(cc_n), .cc_c_in(cc_c), .cc_v_in(cc_v),
        .irq_push(irq_push), .rti_pop(rti_pop), .err_clr(err_clr),
        .psw_out(psw_a), .flags_out(flags_a), .stack_cnt(cnt_a),
        .stack_full(full_a), .stack_empty(empty_a), .ovf_err(ovf_a), .unf_err(unf_a)
    );

    psw_stack #(.DATA_W(8), .DEPTH(1)) u_dut_b (
        .clk(clk), .reset(reset), .data(data_b), .latch(latch), .enable(enable),
        .z_in(z_in), .ir_opcode(ir_opcode), .ir_s(ir_s), .alu_control(alu_control),
        .cc_z_in(cc_z), .cc_n_in(cc_n), .cc_c_in(cc_c), .cc_v_in(cc_v),
        .irq_push(irq_push), .rti_pop(rti_pop), .err_clr(err_clr),
        .psw_out(psw_b), .flags_out(flags_b), .stack_cnt(cnt_b),
        .stack_full(full_b), .stack_empty(empty_b), .ovf_err(ovf_b), .unf_err(unf_b)
    );

    typedef struct {
        int          dut;
        string       name;
        logic [15:0] psw;
        int          cnt;
        logic        full;
        logic        empty;
        logic        ovf;
        logic        unf;
        logic        chk_bus;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Monitor state (written only by the monitor process)
    exp_t        m_e;
    logic [15:0] m_psw, m_bus;
    logic [4:0]  m_flags;
    int          m_cnt;
    logic        m_full, m_empty, m_ovf, m_unf, m_ok;

    // Monitor: compare every queued expectation against the live DUT state
    always @(negedge clk) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            if (m_e.dut == 0) begin
                m_psw = psw_a; m_flags = flags_a; m_cnt = int'(cnt_a);
                m_full = full_a; m_empty = empty_a; m_ovf = ovf_a; m_unf = unf_a;
                m_bus = data_a;
            end else begin
                m_psw = {8'h00, psw_b}; m_flags = flags_b; m_cnt = int'(cnt_b);
                m_full = full_b; m_empty = empty_b; m_ovf = ovf_b; m_unf = unf_b;
                m_bus = {8'h00, data_b};
            end
            m_ok = (m_psw === m_e.psw) && (m_flags === m_e.psw[4:0]) &&
                   (m_cnt == m_e.cnt) && (m_full === m_e.full) &&
                   (m_empty === m_e.empty) && (m_ovf === m_e.ovf) &&
                   (m_unf === m_e.unf) && (!m_e.chk_bus || (m_bus === m_e.psw));
            total++;
            if (!m_ok) begin
                bad++;
                $display("FAIL %s: got psw=%h flags=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b bus=%h ; want psw=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                         m_e.name, m_psw, m_flags, m_cnt, m_full, m_empty, m_ovf, m_unf, m_bus,
                         m_e.psw, m_e.cnt, m_e.full, m_e.empty, m_e.ovf, m_e.unf);
            end
        end
    end

    task automatic exp_a(input string n, input logic [15:0] p, input int c,
                         input logic ov, input logic un, input logic bus = 1'b0);
        exp_t e;
        e.dut = 0; e.name = n; e.psw = p; e.cnt = c;
        e.full = (c == 4); e.empty = (c == 0); e.ovf = ov; e.unf = un; e.chk_bus = bus;
        q.push_back(e);
    endtask

    task automatic exp_b(input string n, input logic [7:0] p, input int c,
                         input logic ov, input logic un);
        exp_t e;
        e.dut = 1; e.name = n; e.psw = {8'h00, p}; e.cnt = c;
        e.full = (c == 1); e.empty = (c == 0); e.ovf = ov; e.unf = un; e.chk_bus = 1'b0;
        q.push_back(e);
    endtask

    // One clock; single-cycle strobes are released just after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
        latch = 0; irq_push = 0; rti_pop = 0; err_clr = 0;
        z_in = 0; ir_s = 0; drv_en = 0;
    endtask

    task automatic do_latch(input logic [15:0] v);
        drv_en = 1; drv_val = v; latch = 1;
        cyc();
    endtask

    task automatic do_push();
        irq_push = 1;
        cyc();
    endtask

    task automatic do_pop();
        rti_pop = 1;
        cyc();
    endtask

    task automatic do_cc(input logic [3:0] op, input logic s, input logic [2:0] alu,
                         input logic z, input logic n, input logic c, input logic v);
        ir_opcode = op; ir_s = s; alu_control = alu; z_in = 1;
        cc_z = z; cc_n = n; cc_c = c; cc_v = v;
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; latch = 0; enable = 0; z_in = 0; ir_s = 0; irq_push = 0;
        rti_pop = 0; err_clr = 0; cc_z = 0; cc_n = 0; cc_c = 0; cc_v = 0;
        ir_opcode = 0; alu_control = 0; drv_en = 0; drv_val = 0;

        // Reset state, PSW visible on the bus
        cyc();
        cyc();
        reset = 0; enable = 1;
        exp_a("reset", 16'h0000, 0, 0, 0, 1'b1);
        exp_b("reset_b", 8'h00, 0, 0, 0);
        cyc();
        enable = 0;

        // Interrupt entry clears IE, return restores it
        do_latch(16'h0010); exp_a("latch_ie",  16'h0010, 0, 0, 0);
        do_push();          exp_a("push_ie",   16'h0000, 1, 0, 0);
        do_pop();           exp_a("pop_ie",    16'h0010, 0, 0, 0);

        // Condition-code path
        do_latch(16'h0000);
        do_cc(4'd2, 1, 3'b001, 1, 0, 0, 1); exp_a("cc_sub",    16'h0009, 0, 0, 0);
        do_latch(16'h0000);
        do_cc(4'd2, 1, 3'b010, 1, 0, 0, 1); exp_a("cc_nocc0",  16'h0000, 0, 0, 0);
        do_cc(4'd2, 0, 3'b001, 1, 0, 0, 1); exp_a("cc_no_s",   16'h0000, 0, 0, 0);
        do_cc(4'd6, 1, 3'b001, 1, 0, 0, 1); exp_a("cc_op6",    16'h0000, 0, 0, 0);
        do_cc(4'd5, 1, 3'b000, 0, 1, 1, 0); exp_a("cc_op5add", 16'h0006, 0, 0, 0);
        do_cc(4'd1, 1, 3'b011, 1, 0, 0, 1); exp_a("cc_logic",  16'h0005, 0, 0, 0);

        // Latch beats a qualified CC update in the same cycle
        ir_opcode = 4'd1; ir_s = 1; alu_control = 3'b000; z_in = 1;
        cc_z = 1; cc_n = 1; cc_c = 1; cc_v = 1;
        do_latch(16'h00A0); exp_a("latch_over_cc", 16'h00A0, 0, 0, 0);

        // Fill the stack, overflow, then unwind in LIFO order
        do_latch(16'h1111); do_push(); exp_a("push1", 16'h1101, 1, 0, 0);
        do_latch(16'h2222); do_push(); exp_a("push2", 16'h2222, 2, 0, 0);
        do_latch(16'h3333); do_push(); exp_a("push3", 16'h3323, 3, 0, 0);
        do_latch(16'h4444); do_push(); exp_a("push4", 16'h4444, 4, 0, 0);
        do_latch(16'h5555); do_push(); exp_a("push_ovf", 16'h5545, 4, 1, 0);
        do_pop(); exp_a("pop1", 16'h4444, 3, 1, 0);
        do_pop(); exp_a("pop2", 16'h3333, 2, 1, 0);
        do_pop(); exp_a("pop3", 16'h2222, 1, 1, 0);
        do_pop(); exp_a("pop4", 16'h1111, 0, 1, 0);
        do_pop(); exp_a("pop_unf", 16'h1111, 0, 1, 1);
        err_clr = 1; cyc(); exp_a("err_clr", 16'h1111, 0, 0, 0);

        // New error in the clearing cycle keeps the flag set
        err_clr = 1; rti_pop = 1; cyc(); exp_a("clr_vs_unf", 16'h1111, 0, 0, 1);
        err_clr = 1; cyc(); exp_a("err_clr2", 16'h1111, 0, 0, 0);

        // Tail-chain: only IE changes, no stack activity, no error
        do_latch(16'h0013);
        irq_push = 1; rti_pop = 1; cyc(); exp_a("tail_chain", 16'h0003, 0, 0, 0);

        // Reset wins over a held push
        do_latch(16'h0010);
        do_push(); do_push(); do_push(); exp_a("pre_reset", 16'h0000, 3, 0, 0);
        reset = 1; irq_push = 1; cyc(); reset = 0;
        exp_a("reset_mid",   16'h0000, 0, 0, 0);
        exp_b("reset_mid_b", 8'h00, 0, 0, 0);

        // Narrow, single-entry instance
        do_latch(16'h0013); exp_b("b_latch",    8'h13, 0, 0, 0);
        do_push();          exp_b("b_push",     8'h03, 1, 0, 0);
        do_push();          exp_b("b_push_ovf", 8'h03, 1, 1, 0);
        do_pop();           exp_b("b_pop",      8'h13, 0, 1, 0);
        do_pop();           exp_b("b_pop_unf",  8'h13, 0, 1, 1);
        reset = 1; irq_push = 1; cyc(); reset = 0;
        exp_b("b_reset", 8'h00, 0, 0, 0);

        cyc();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations ; want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_psw_stack
`default_nettype wire

// File: doc/psw_stack.md
Name: psw_stack

Overview:
- Parametrised processor status word with a hardware save/restore stack for interrupt entry and return.
- Holds the condition codes Z, N, C and V, an interrupt-enable bit IE, and general-purpose upper bits.
- Shares the tri-state system data bus with the other registers and updates its flags from the ALU comparator.
- Sits beside the ALU and control FSM; the interrupt controller drives push on entry and pop on return (RTI).

Parameters:
- DATA_W, 16, width of the PSW and the bus; must be >= 8.
- DEPTH, 4, number of saved PSW entries; must be >= 1.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- data  inout  DATA_W  shared system bus.
- latch  in  1  load the PSW from data.
- enable  in  1  drive the PSW onto data; otherwise the port is high-Z.
- z_in  in  1  ALU result-valid strobe.
- ir_opcode  in  4  IR opcode field.
- ir_s  in  1  IR set-condition-codes bit.
- alu_control  in  3  ALU operation select.
- cc_z_in, cc_n_in, cc_c_in, cc_v_in  in  1 each  comparator/ALU flag results.
- irq_push  in  1  interrupt entry: save the PSW and clear IE.
- rti_pop  in  1  interrupt return: restore the PSW.
- err_clr  in  1  clear the sticky error flags.
- psw_out  out  DATA_W  current PSW, always visible.
- flags_out  out  5  {IE,V,C,N,Z} = psw[4:0].
- stack_cnt  out  CNT_W  number of saved entries.
- stack_full, stack_empty  out  1  stack_cnt==DEPTH, stack_cnt==0.
- ovf_err, unf_err  out  1  sticky overflow (push when full) and underflow (pop when empty).

Behaviour:
- Bit layout: psw[0]=Z, [1]=N, [2]=C, [3]=V, [4]=IE; [DATA_W-1:5] plain storage.
- Reset: psw=0, stack_cnt=0, stack entries=0, ovf_err=0, unf_err=0, so stack_empty=1 and stack_full=0.
- PSW update priority, one action per cycle, highest first:
  - (1) reset.
  - (2) irq_push & rti_pop together: tail-chain; PSW and stack unchanged, IE forced to 0.
  - (3) rti_pop alone:
    - non-empty: psw <= top entry; stack_cnt decrements.
    - empty: psw unchanged; unf_err <= 1.
  - (4) irq_push alone:
    - not full: top entry <= psw; stack_cnt increments; psw[4] <= 0; other PSW bits unchanged.
    - full: stack unchanged; ovf_err <= 1; psw[4] <= 0 regardless.
  - (5) latch: psw <= data.
  - (6) CC update.
- CC update conditions:
  - Qualified when ir_opcode <= 5, z_in=1, ir_s=1, and alu_control is neither 3'b111 nor 3'b010.
  - When qualified: Z <= cc_z_in and N <= cc_n_in.
  - C and V update only when alu_control is 3'b000 (add) or 3'b001 (sub); otherwise they hold.
  - All other bits hold.
- Suppression: a CC update is dropped, not deferred, in any cycle where a higher-priority action fires.
- Latency: every action takes effect one clock after it is sampled. psw_out, flags_out, stack_cnt and the status outputs are registered or derived purely from registers; no input-to-output combinational paths.
- Bus: data = enable ? psw : high-Z. latch and enable together reload the PSW with its own value, i.e. no change.
- Stack is a LIFO: entry index stack_cnt-1 is the top. Pop reads the top entry as of the sampling edge.
- Errors: ovf_err and unf_err are sticky until reset or err_clr. If err_clr and a new error occur in the same cycle, the error wins and the flag stays 1.
- Reset mid-sequence, e.g. with irq_push held: reset wins and the stack is emptied.

Decomposition:
- Package psw_pkg holds:
  - bit-index constants PSW_Z=0, PSW_N=1, PSW_C=2, PSW_V=3, PSW_IE=4;
  - ALU op constants ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_NOCC0=3'b010, ALU_NOCC1=3'b111;
  - CC_OPCODE_MAX=4'd5.
- One sub-module, psw_lifo (parameters DATA_W and DEPTH), owns the storage array, stack_cnt and full/empty. It accepts push/pop/data_in and gives top_out.
- psw_stack owns the PSW register, the priority logic, the CC qualification, the error flags and the tri-state driver.

Test Plan:
- Reset then enable=1 -> data=16'h0000, stack_empty=1, stack_cnt=0, flags_out=5'b00000.
- latch with data=16'h0010 (IE=1); then irq_push -> next cycle stack_cnt=1, psw=16'h0000; then rti_pop -> psw=16'h0010, stack_empty=1.
- CC path, psw=0:
  - ir_opcode=2, ir_s=1, z_in=1, alu_control=3'b001, cc_z=1, cc_v=1 -> psw=16'h0009.
  - Repeat with alu_control=3'b010 -> psw unchanged.
  - Repeat with ir_s=0 -> psw unchanged.
- DEPTH=4, after latching a distinct value before each push:
  - 4 pushes -> stack_full=1.
  - 5th push -> ovf_err=1, stack_cnt=4, IE=0.
  - 4 pops restore the 4 latched values in reverse order.
  - 5th pop -> unf_err=1; err_clr -> both errors 0.
- Simultaneous events:
  - irq_push+rti_pop with psw=16'h0013 -> psw=16'h0003, stack_cnt unchanged.
  - latch + qualified CC update same cycle -> latched value wins.
- reset asserted with stack_cnt=3 and irq_push=1 -> stack_cnt=0, psw=0, errors 0; rerun with DATA_W=8, DEPTH=1.
